// File: rtl/color_input_ctrl.sv
// Button front end for the color selector: synchronizes and debounces three color buttons
// plus a bus-select button, turns color presses into single-cycle step pulses with optional
// hold-to-repeat, and toggles the character/background bus select on each select press.
module color_input_ctrl #(
    parameter int unsigned DEB_CYCLES  = 250000,
    parameter int unsigned HOLD_CYCLES = 25000000,
    parameter int unsigned RPT_CYCLES  = 12500000,
    parameter int unsigned CNT_W       = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btnRaw,
    input  logic       selBtnRaw,
    input  logic       repeatEn,
    output logic [2:0] rgbEn,
    output logic       select
);

    localparam logic [CNT_W-1:0] DebLimit = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RptLast  = CNT_W'(RPT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRepeat
    } state_e;

    // Channel 3 is the select button, channels 2..0 are Blue, Green, Red.
    logic [3:0] raw_all;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] db;
    logic [3:0] db_toggle;

    assign raw_all = {selBtnRaw, btnRaw};

    // Two-flop synchronizer for all four raw buttons
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_all;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             db_q;

        // Flip only once the mismatch has outlasted the full debounce window
        assign db_toggle[g] = (sync2[g] != db_q) && (cnt == DebLimit);
        assign db[g]        = db_q;

        // Debounce counter: any matching cycle restarts the count
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt  <= '0;
                db_q <= 1'b0;
            end else begin
                if ((sync2[g] == db_q) || db_toggle[g]) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CntOne;
                end
                if (db_toggle[g]) begin
                    db_q <= ~db_q;
                end
            end
        end
    end

    // Bus select flips on the debounced rising edge of the select button only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            select <= 1'b0;
        end else if (db_toggle[3] && !db[3]) begin
            select <= ~select;
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_color
        state_e           state;
        logic [CNT_W-1:0] timer;
        logic             pulse_q;

        assign rgbEn[c] = pulse_q;

        // Press / hold / auto-repeat FSM with a registered one-cycle step pulse
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= StIdle;
                timer   <= '0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                if ((state != StIdle) && !db[c]) begin
                    // Release wins over any pending repeat pulse
                    state <= StIdle;
                    timer <= '0;
                end else begin
                    case (state)
                        StIdle: begin
                            if (db[c]) begin
                                pulse_q <= 1'b1;
                                timer   <= '0;
                                state   <= StHold;
                            end
                        end
                        StHold: begin
                            if (timer == HoldLast) begin
                                // Timer saturates here until repeat is enabled
                                if (repeatEn) begin
                                    pulse_q <= 1'b1;
                                    timer   <= '0;
                                    state   <= StRepeat;
                                end
                            end else begin
                                timer <= timer + CntOne;
                            end
                        end
                        StRepeat: begin
                            if (!repeatEn) begin
                                // Park in HOLD already expired so re-enabling fires at once
                                state <= StHold;
                                timer <= HoldLast;
                            end else if (timer == RptLast) begin
                                pulse_q <= 1'b1;
                                timer   <= '0;
                            end else begin
                                timer <= timer + CntOne;
                            end
                        end
                        default: begin
                            state <= StIdle;
                            timer <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
